// File: rtl/e3_mult_arb_pkg.sv
// Shared definitions for the Excess-3 multiplier arbiter: legal digit range,
// FSM state encodings and a digit legality helper.
package e3_mult_arb_pkg;

    localparam logic [3:0] E3_MIN = 4'b0011;
    localparam logic [3:0] E3_MAX = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic e3Legal(input logic [3:0] digit);
        return (digit >= E3_MIN) && (digit <= E3_MAX);
    endfunction

endpackage

// File: rtl/e3_mult.sv
// Combinational Excess-3 digit multiplier: two E3 digits in, two-digit E3 product out.
// Inputs outside the E3 range give an unspecified product; callers screen them.
module e3_mult (
    input  logic [3:0] in_0,
    input  logic [3:0] in_1,
    output logic [7:0] out
);

    logic [7:0] prod;
    logic [3:0] tens;
    logic [3:0] units;

    always_comb begin
        prod  = {4'b0000, in_0 - 4'd3} * {4'b0000, in_1 - 4'd3};
        tens  = 4'(prod / 8'd10);
        units = 4'(prod % 8'd10);
        out   = {tens + 4'd3, units + 4'd3};
    end

endmodule

// File: rtl/e3_mult_arb.sv
// Round-robin arbiter/sequencer sharing one e3_mult among N_REQ requesters;
// one operation every three cycles, result tagged with the requester id.
module e3_mult_arb
    import e3_mult_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   op_a,
    input  logic [4*N_REQ-1:0]   op_b,
    output logic [N_REQ-1:0]     gnt,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [7:0]           res,
    output logic                 res_err
);

    logic [1:0]       state_q,  state_d;
    logic [ID_W-1:0]  ptr_q,    ptr_d;
    logic [ID_W-1:0]  id_q,     id_d;
    logic [3:0]       a_q,      a_d;
    logic [3:0]       b_q,      b_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic             valid_q,  valid_d;
    logic [ID_W-1:0]  resId_q,  resId_d;
    logic [7:0]       res_q,    res_d;
    logic             err_q,    err_d;

    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic [7:0]       multOut;

    e3_mult u_mult (
        .in_0 (a_q),
        .in_1 (b_q),
        .out  (multOut)
    );

    // First asserted request at or after ptr, wrapping past N_REQ-1 to 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = ID_W'((int'(ptr_q) + off) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        resId_d = resId_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    id_d        = pick;
                    a_d         = op_a[pick*4 +: 4];
                    b_d         = op_b[pick*4 +: 4];
                    gnt_d[pick] = 1'b1;
                    state_d     = ST_MUL;
                end
            end
            ST_MUL: begin
                valid_d = 1'b1;
                resId_d = id_q;
                if (e3Legal(a_q) && e3Legal(b_q)) begin
                    res_d = multOut;
                    err_d = 1'b0;
                end else begin
                    res_d = 8'h00;
                    err_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            resId_q <= '0;
            res_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            resId_q <= resId_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = valid_q;
    assign res_id    = resId_q;
    assign res       = res_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_e3_mult_arb.sv
// Self-checking bench for e3_mult_arb: directed cases plus randomized traffic
// compared against a decimal-arithmetic round-robin reference model.
module tb_e3_mult_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  gnt;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [7:0]  res;
    logic        res_err;

    int compareCount  = 0;
    int mismatchCount = 0;
    int modelPtr      = 0;

    e3_mult_arb #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res       (res),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b);
        req  = r;
        op_a = a;
        op_b = b;
    endtask

    function automatic int expWinner(input logic [3:0] r, input int ptr);
        for (int off = 0; off < 4; off++) begin
            if (r[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    // Returns {err, tens_e3, units_e3} from plain decimal arithmetic.
    function automatic logic [8:0] expResult(input logic [3:0] a, input logic [3:0] b);
        int da, db, p;
        da = int'(a) - 3;
        db = int'(b) - 3;
        if (da < 0 || da > 9 || db < 0 || db > 9) return 9'h100;
        p = da * db;
        return {1'b0, 4'(p / 10 + 3), 4'(p % 10 + 3)};
    endfunction

    function automatic logic [3:0] randDigit();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(3, 12));
    endfunction

    // One arbitration round: sample edge, MUL edge, DONE edge.
    task automatic runOp(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b);
        int w;
        logic [8:0] e;
        @(negedge clk);
        applyStimulus(r, a, b);
        @(posedge clk);
        #1;
        if (r == 4'b0000) begin
            checkOutput("idle_gnt", 32'(gnt), 32'd0);
            checkOutput("idle_valid", 32'(res_valid), 32'd0);
            return;
        end
        w = expWinner(r, modelPtr);
        e = expResult(a[4*w +: 4], b[4*w +: 4]);
        checkOutput("gnt", 32'(gnt), 32'(1 << w));
        checkOutput("valid_early", 32'(res_valid), 32'd0);
        applyStimulus(r, 16'($urandom), 16'($urandom));
        @(posedge clk);
        #1;
        checkOutput("res_valid", 32'(res_valid), 32'd1);
        checkOutput("res_id", 32'(res_id), 32'(w));
        checkOutput("res", 32'(res), 32'(e[7:0]));
        checkOutput("res_err", 32'(res_err), 32'(e[8]));
        checkOutput("gnt_drop", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("valid_drop", 32'(res_valid), 32'd0);
        checkOutput("res_hold", 32'(res), 32'(e[7:0]));
        modelPtr = (w + 1) % 4;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rr;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res", 32'(res), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(4'b0001, 16'h333A, 16'h333B);
        runOp(4'b0001, 16'h333C, 16'h333C);
        runOp(4'b0001, 16'h3333, 16'h333C);
        runOp(4'b0001, 16'h333D, 16'h3334);
        runOp(4'b0001, 16'h3335, 16'h3336);

        modelPtr = modelPtr;
        for (int k = 0; k < 5; k++) runOp(4'b1111, 16'h6789, 16'hABC4);
        // Serving id 2 leaves the pointer at 3 for the wrap/fairness case.
        runOp(4'b0100, 16'h0500, 16'h0700);
        for (int k = 0; k < 3; k++) runOp(4'b1001, 16'h9334, 16'h5336);

        // Asynchronous reset in the middle of MUL abandons the operation.
        @(negedge clk);
        applyStimulus(4'b0010, 16'h00C0, 16'h00B0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_gnt", 32'(gnt), 32'd0);
        checkOutput("midrst_valid", 32'(res_valid), 32'd0);
        checkOutput("midrst_id", 32'(res_id), 32'd0);
        checkOutput("midrst_res", 32'(res), 32'd0);
        checkOutput("midrst_err", 32'(res_err), 32'd0);
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_novalid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelPtr = 0;
        for (int k = 0; k < 3; k++) runOp(4'b0000, 16'h0000, 16'h0000);

        for (int k = 0; k < 60; k++) begin
            rr = 4'($urandom_range(0, 15));
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = randDigit();
                rb[4*d +: 4] = randDigit();
            end
            runOp(rr, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
